sop_minterm_scanner: RTL and testbench
======================================

Name: sop_minterm_scanner

Overview:
- Sequential truth-table extractor; the inverse of our mux-based SOP implementations.
- It drives all 16 patterns of a 4-input combinational function-under-test (FUT), samples the FUT output for each, and assembles the canonical minterm mask Σm(...) plus a minterm count.
- Sits beside any 4-input SOP/mux block as a self-check/characterisation engine: board-level BIST or bench golden-model capture.

Parameters:
- SETTLE, 2, clock cycles the pattern is held before sampling y_in (range 0..15).
- CW, 4, width of the settle counter; must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE or DONE.
- abort  input  1  synchronous abort; returns to IDLE without done.
- y_in  input  1  FUT output, combinational from a,b,c,d.
- a  output  1  pattern MSB, weight 8.
- b  output  1  pattern bit, weight 4.
- c  output  1  pattern bit, weight 2.
- d  output  1  pattern LSB, weight 1.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when results are valid.
- minterms  output  16  bit k = FUT value for pattern k ({a,b,c,d}=k).
- count  output  5  number of ones in minterms (0..16).

Behaviour:
- Reset (async, rst=1): state=IDLE; a=b=c=d=0; busy=0; done=0; minterms=16'h0000; count=0; idx=0; settle counter=0.
- States: IDLE, APPLY, DONE.
- IDLE:
  - outputs a..d=0.
  - start=1 → APPLY with idx=0, cnt=0, minterms cleared to 0, count cleared to 0.
- APPLY:
  - {a,b,c,d} = idx, registered, so it changes on the cycle the state or idx changes.
  - busy=1.
  - Each cycle cnt increments. When cnt==SETTLE: minterms[idx] <= y_in, count <= count + y_in, cnt <= 0.
  - If idx==15 on that cycle → DONE; else idx <= idx+1.
  - Each pattern therefore occupies exactly SETTLE+1 cycles. SETTLE=0 means sample on the first cycle the pattern is driven.
- DONE:
  - done=1 for exactly this one cycle; busy=0; a..d return to 0.
  - Next cycle → IDLE, unless start=1 in this cycle, which re-enters APPLY directly (back-to-back scans).
- Latency: start seen at edge T → busy high for cycles T+1 .. T+16·(SETTLE+1) → done high at cycle T+16·(SETTLE+1)+1.
  - SETTLE=2: 48 busy cycles; done at T+49.
- start while busy: ignored, no restart.
- abort:
  - Highest priority after rst, any state. Next state IDLE; busy=0; done not asserted; a..d=0.
  - minterms/count are left at their partial values and are undefined to consumers.
- Simultaneous start and abort in IDLE/DONE: abort wins, stay/go IDLE.
- Reset mid-scan: immediate clear per reset list; no done.
- Results (minterms, count) hold stable from the done pulse until the next accepted start.
- count never exceeds 16; 5-bit width is required (all-ones function gives 16).
- y_in is assumed combinationally driven from a..d in the same clock domain; no synchroniser.

Decomposition:
- Shared package sop_pkg:
  - state enum (IDLE=2'd0, APPLY=2'd1, DONE=2'd2);
  - constants N_VARS=4, N_PATTERNS=16.
- One natural sub-module, settle_counter: CW-bit counter with clear, enable and terminal flag (cnt==SETTLE), reusable by other scan engines.
- FSM, pattern register and result registers stay in the top.

Test Plan:
- Reset then idle, no start → all outputs 0, busy=0 indefinitely; assert rst mid-idle → no glitch on done.
- Connect FUT y=Σm(1,3,4,11,12,13,14,15), SETTLE=2, pulse start → done at T+49; minterms=16'hF81A; count=8; a..d walk 0..15, each held 3 cycles.
- FUT y=1'b1 with SETTLE=0 → done at T+17, minterms=16'hFFFF, count=16. FUT y=1'b0 → minterms=16'h0000, count=0.
- FUT y=a^b^c^d, scan, then pulse start during the done cycle → back-to-back second scan with no IDLE cycle. Both results: minterms=16'h6996, count=8.
- Start during APPLY (cycle T+10) is ignored → done still at T+49. abort at T+20 → busy=0 next cycle, no done pulse. A following start → full clean scan with correct mask.
- Assert rst at T+30 of a scan → outputs zero asynchronously (before next clk edge). After release plus start → correct result, no stale bits from the aborted scan.

Source files
------------

// File: rtl/sop_pkg.sv
// Shared types and constants for the SOP minterm scanner.
// Covers the FSM state encoding and the 4-input problem size.
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_VARS     = 4;
    localparam int N_PATTERNS = 16;

    function automatic logic [N_VARS-1:0] next_pattern(
        input logic [N_VARS-1:0] i
    );
        return i + N_VARS'(1);
    endfunction

endpackage

// File: rtl/sop_minterm_scanner_settle.sv
// Settle counter: counts held cycles of a pattern and flags the sample cycle.
// Wraps to zero on the terminal cycle so consecutive patterns need no clear.
module settle_counter #(
    parameter int SETTLE = 2,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          terminal
);

    assign terminal = (cnt == CW'(SETTLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= terminal ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sop_minterm_scanner.sv
// Walks all 16 input patterns of a 4-input function and captures its
// truth table as a minterm mask plus a population count.
module sop_minterm_scanner
    import sop_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] minterms,
    output logic [4:0]  count
);

    state_t              state;
    logic [N_VARS-1:0]   idx;
    logic [N_VARS-1:0]   pat;
    logic [CW-1:0]       cnt;
    logic                settled;
    logic                cnt_clear;
    logic                cnt_en;

    localparam logic [N_VARS-1:0] LAST = N_VARS'(N_PATTERNS - 1);

    assign cnt_clear = abort || (state != APPLY);
    assign cnt_en    = (state == APPLY);

    settle_counter #(
        .SETTLE (SETTLE),
        .CW     (CW)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .cnt      (cnt),
        .terminal (settled)
    );

    assign {a, b, c, d} = pat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            pat      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            minterms <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            // abort leaves partial results in place; consumers ignore them
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                pat   <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        pat  <= '0;
                        if (start) begin
                            state    <= APPLY;
                            idx      <= '0;
                            busy     <= 1'b1;
                            minterms <= '0;
                            count    <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    APPLY: begin
                        if (settled) begin
                            minterms[idx] <= y_in;
                            count         <= count + 5'(y_in);
                            if (idx == LAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pat   <= '0;
                            end else begin
                                idx <= next_pattern(idx);
                                pat <= next_pattern(idx);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pat   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sop_minterm_scanner.sv
// Bench for sop_minterm_scanner: two instances (SETTLE=2 and SETTLE=0)
// scan the same function table, checked against a minterm-list model.
module tb_sop_minterm_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [15:0] fut_tab = '0;

    logic a2, b2, c2, d2, busy2, done2, y2;
    logic a0, b0, c0, d0, busy0, done0, y0;
    logic [15:0] minterms2, minterms0;
    logic [4:0] count2, count0;
    logic [3:0] pat2, pat0;

    int checks = 0;
    int failures = 0;

    int q[$];
    int exp_mask;
    int exp_count;

    int d2_first, d2_second, d0_first, d0_second;
    int busy2_n, busy0_n, walk2_err, walk0_err;
    logic [15:0] m2_first;
    logic [4:0] c2_first;

    always #5 clk = ~clk;

    assign pat2 = {a2, b2, c2, d2};
    assign pat0 = {a0, b0, c0, d0};
    assign y2 = fut_tab[pat2];
    assign y0 = fut_tab[pat0];

    sop_minterm_scanner #(.SETTLE(2), .CW(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
        .minterms(minterms2), .count(count2)
    );

    sop_minterm_scanner #(.SETTLE(0), .CW(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .minterms(minterms0), .count(count0)
    );

    // Model: the function is a list of true minterms; the mask and count
    // follow directly from that list.
    task automatic load_fut();
        fut_tab = '0;
        exp_mask = 0;
        foreach (q[i]) begin
            fut_tab[q[i]] = 1'b1;
            exp_mask += (1 << q[i]);
        end
        exp_count = q.size();
    endtask

    task automatic random_fut();
        q = {};
        for (int k = 0; k < 16; k++)
            if ($urandom_range(0, 1) == 1) q.push_back(k);
        load_fut();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Records timing/pattern observations after a start pulse; no checks here.
    task automatic observe(input int ncyc, input int inj_start, input int inj_abort);
        d2_first = -1; d2_second = -1; d0_first = -1; d0_second = -1;
        busy2_n = 0; busy0_n = 0; walk2_err = 0; walk0_err = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (busy2) begin
                busy2_n++;
                if (k <= 48 && pat2 !== 4'((k - 1) / 3)) walk2_err++;
            end else if (pat2 !== 4'd0) walk2_err++;
            if (busy0) begin
                busy0_n++;
                if (k <= 16 && pat0 !== 4'(k - 1)) walk0_err++;
            end else if (pat0 !== 4'd0) walk0_err++;
            if (done2) begin
                if (d2_first < 0) begin
                    d2_first = k; m2_first = minterms2; c2_first = count2;
                end else if (d2_second < 0) d2_second = k;
            end
            if (done0) begin
                if (d0_first < 0) d0_first = k;
                else if (d0_second < 0) d0_second = k;
            end
            start = (k == inj_start);
            abort = (k == inj_abort);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        int err;
        err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({busy2, done2, pat2, minterms2, count2} !== '0) err++;
            if ({busy0, done0, pat0, minterms0, count0} !== '0) err++;
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL reset_idle nonzero_samples=%0d required=0", err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({done2, done0, busy2, busy0} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_idle flags=%b required=0000", {done2, done0, busy2, busy0});
        end
        @(negedge clk);
        rst = 1'b0;
        err = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done2 !== 1'b0 || done0 !== 1'b0) err++;
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL reset_release_done done_samples=%0d required=0", err);
        end
    endtask

    task automatic test_sigma();
        q = {1, 3, 4, 11, 12, 13, 14, 15};
        load_fut();
        pulse_start();
        observe(60, -1, -1);
        checks++;
        if (d2_first !== 49) begin
            failures++; $display("FAIL sigma_done_s2 got=%0d required=49", d2_first);
        end
        checks++;
        if (busy2_n !== 48) begin
            failures++; $display("FAIL sigma_busy_s2 got=%0d required=48", busy2_n);
        end
        checks++;
        if (walk2_err !== 0) begin
            failures++; $display("FAIL sigma_walk_s2 bad_cycles=%0d required=0", walk2_err);
        end
        checks++;
        if (minterms2 !== 16'hF81A) begin
            failures++; $display("FAIL sigma_mask_s2 got=%h required=f81a", minterms2);
        end
        checks++;
        if (count2 !== 5'd8) begin
            failures++; $display("FAIL sigma_count_s2 got=%0d required=8", count2);
        end
        checks++;
        if (d0_first !== 17 || walk0_err !== 0) begin
            failures++;
            $display("FAIL sigma_timing_s0 done=%0d walk_err=%0d required=17,0", d0_first, walk0_err);
        end
        checks++;
        if (minterms0 !== 16'hF81A || count0 !== 5'd8) begin
            failures++;
            $display("FAIL sigma_result_s0 got=%h/%0d required=f81a/8", minterms0, count0);
        end
    endtask

    task automatic test_constants();
        q = {};
        for (int k = 0; k < 16; k++) q.push_back(k);
        load_fut();
        pulse_start();
        observe(55, -1, -1);
        checks++;
        if (d0_first !== 17 || minterms0 !== 16'hFFFF || count0 !== 5'd16) begin
            failures++;
            $display("FAIL ones_s0 done=%0d mask=%h count=%0d required=17/ffff/16", d0_first, minterms0, count0);
        end
        checks++;
        if (minterms2 !== 16'hFFFF || count2 !== 5'd16) begin
            failures++;
            $display("FAIL ones_s2 mask=%h count=%0d required=ffff/16", minterms2, count2);
        end
        q = {};
        load_fut();
        pulse_start();
        observe(55, -1, -1);
        checks++;
        if (minterms0 !== 16'h0000 || count0 !== 5'd0 || minterms2 !== 16'h0000 || count2 !== 5'd0) begin
            failures++;
            $display("FAIL zeros got=%h/%0d %h/%0d required=0000/0", minterms2, count2, minterms0, count0);
        end
    endtask

    task automatic test_back_to_back();
        q = {};
        for (int k = 0; k < 16; k++)
            if (((k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1) + ((k >> 3) & 1)) % 2 == 1)
                q.push_back(k);
        load_fut();
        pulse_start();
        observe(110, 49, -1);
        checks++;
        if (m2_first !== 16'h6996 || c2_first !== 5'd8) begin
            failures++;
            $display("FAIL b2b_first got=%h/%0d required=6996/8", m2_first, c2_first);
        end
        checks++;
        if (d2_first !== 49 || d2_second !== 98) begin
            failures++;
            $display("FAIL b2b_done got=%0d,%0d required=49,98", d2_first, d2_second);
        end
        checks++;
        if (busy2_n !== 96) begin
            failures++; $display("FAIL b2b_busy got=%0d required=96", busy2_n);
        end
        checks++;
        if (minterms2 !== 16'h6996 || count2 !== 5'd8) begin
            failures++;
            $display("FAIL b2b_second got=%h/%0d required=6996/8", minterms2, count2);
        end
        checks++;
        if (d0_second !== 66 || minterms0 !== 16'h6996) begin
            failures++;
            $display("FAIL b2b_s0 done2=%0d mask=%h required=66/6996", d0_second, minterms0);
        end
    endtask

    task automatic test_start_abort();
        random_fut();
        pulse_start();
        observe(60, 10, -1);
        checks++;
        if (d2_first !== 49 || d2_second !== -1 || busy2_n !== 48) begin
            failures++;
            $display("FAIL start_ignored done=%0d,%0d busy=%0d required=49,-1,48", d2_first, d2_second, busy2_n);
        end
        checks++;
        if (minterms2 !== 16'(exp_mask) || count2 !== 5'(exp_count)) begin
            failures++;
            $display("FAIL start_ignored_result got=%h/%0d required=%h/%0d", minterms2, count2, 16'(exp_mask), exp_count);
        end
        pulse_start();
        observe(60, -1, 20);
        checks++;
        if (busy2_n !== 20 || d2_first !== -1) begin
            failures++;
            $display("FAIL abort busy_cycles=%0d done=%0d required=20,-1", busy2_n, d2_first);
        end
        random_fut();
        pulse_start();
        observe(60, -1, -1);
        checks++;
        if (d2_first !== 49 || minterms2 !== 16'(exp_mask) || count2 !== 5'(exp_count)) begin
            failures++;
            $display("FAIL after_abort done=%0d got=%h/%0d required=49/%h/%0d", d2_first, minterms2, count2, 16'(exp_mask), exp_count);
        end
    endtask

    task automatic test_reset_mid_scan();
        q = {};
        for (int k = 0; k < 16; k++) q.push_back(k);
        load_fut();
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy2, done2, pat2, minterms2, count2} !== '0) begin
            failures++;
            $display("FAIL rst_async busy=%b done=%b pat=%h mask=%h count=%0d required=all0", busy2, done2, pat2, minterms2, count2);
        end
        @(negedge clk);
        rst = 1'b0;
        random_fut();
        pulse_start();
        observe(60, -1, -1);
        checks++;
        if (d2_first !== 49 || minterms2 !== 16'(exp_mask) || count2 !== 5'(exp_count)) begin
            failures++;
            $display("FAIL rst_rescan done=%0d got=%h/%0d required=49/%h/%0d", d2_first, minterms2, count2, 16'(exp_mask), exp_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            random_fut();
            pulse_start();
            observe(52, -1, -1);
            checks++;
            if (minterms2 !== 16'(exp_mask) || count2 !== 5'(exp_count) || walk2_err !== 0) begin
                failures++;
                $display("FAIL random_s2[%0d] got=%h/%0d walk_err=%0d required=%h/%0d", n, minterms2, count2, walk2_err, 16'(exp_mask), exp_count);
            end
            checks++;
            if (minterms0 !== 16'(exp_mask) || count0 !== 5'(exp_count) || d0_first !== 17) begin
                failures++;
                $display("FAIL random_s0[%0d] got=%h/%0d done=%0d required=%h/%0d/17", n, minterms0, count0, d0_first, 16'(exp_mask), exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sigma();
        test_constants();
        test_back_to_back();
        test_start_abort();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
